// File: rtl/alu_pkg.sv
// Shared definitions for the UART ALU command/response framing path.
// Holds the response framer state type, the frame constants and the status flag positions.
package alu_pkg;

  localparam int RESULT_BYTES_DEF = 4;
  localparam logic [7:0] RESP_HEADER = 8'hA5;

  // Bit positions inside the status byte; bits 7:4 are reserved and pass through.
  localparam int STAT_ZERO  = 0;
  localparam int STAT_CARRY = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_DIV0  = 3;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    STAT,
    DATA,
    CSUM
  } resp_state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/alu_resp_tx_if.sv
// Result-input and byte-stream-output handshakes of the response framer.
// The master modport is the surroundings (ALU + uart_tx); the slave modport is the framer.
interface alu_resp_tx_if
  import alu_pkg::*;
#(
  parameter int RESULT_BYTES = RESULT_BYTES_DEF
);

  logic [8*RESULT_BYTES-1:0] s_result_tdata;
  logic [7:0]                s_result_tstatus;
  logic                      s_result_tvalid;
  logic                      s_result_tready;
  logic [7:0]                m_axis_tdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;

  modport master (
    output s_result_tdata,
    output s_result_tstatus,
    output s_result_tvalid,
    input  s_result_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready
  );

  modport slave (
    input  s_result_tdata,
    input  s_result_tstatus,
    input  s_result_tvalid,
    output s_result_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready
  );

endinterface

// File: rtl/alu_resp_tx.sv
// Response framer: captures one ALU result + status and sends
// HEADER, status, result bytes (LSB first), checksum as a byte stream to uart_tx.
module alu_resp_tx
  import alu_pkg::*;
#(
  parameter int         DATA_WIDTH   = 8,
  parameter int         RESULT_BYTES = RESULT_BYTES_DEF,
  parameter logic [7:0] HEADER       = RESP_HEADER
) (
  input  logic clk,
  input  logic rst,
  alu_resp_tx_if.slave bus,
  output logic busy
);

  localparam int CW = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(RESULT_BYTES - 1);

  resp_state_t state, state_next;

  logic [CW-1:0]             idx;
  logic [7:0]                csum;
  logic [8*RESULT_BYTES-1:0] result_q;
  logic [7:0]                status_q;
  logic [7:0]                cur_byte;
  logic [DATA_WIDTH-1:0]     tdata_c;
  logic                      capture;
  logic                      accept;

  assign capture  = bus.s_result_tvalid && (state == IDLE);
  assign accept   = (state != IDLE) && bus.m_axis_tready;
  assign cur_byte = result_q[8*idx +: 8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tdata_c    = '0;
    case (state)
      IDLE: begin
        if (capture) state_next = HDR;
      end
      HDR: begin
        tdata_c = HEADER;
        if (accept) state_next = STAT;
      end
      STAT: begin
        tdata_c = status_q;
        if (accept) state_next = DATA;
      end
      DATA: begin
        tdata_c = cur_byte;
        if (accept && (idx == LAST_IDX)) state_next = CSUM;
      end
      CSUM: begin
        tdata_c = csum;
        if (accept) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Every field only moves on capture or on an accepted byte, so tdata holds under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      csum     <= '0;
      result_q <= '0;
      status_q <= '0;
    end else if (capture) begin
      idx      <= '0;
      csum     <= '0;
      result_q <= bus.s_result_tdata;
      status_q <= bus.s_result_tstatus;
    end else if (accept) begin
      case (state)
        STAT: begin
          csum <= csum_add(csum, status_q);
          idx  <= '0;
        end
        DATA: begin
          csum <= csum_add(csum, cur_byte);
          idx  <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.m_axis_tdata    = tdata_c;
  assign bus.m_axis_tvalid   = (state != IDLE);
  assign bus.s_result_tready = (state == IDLE);
  assign busy                = (state != IDLE);

endmodule

// File: doc/alu_resp_tx.md
Name: alu_resp_tx

Overview:
- Response framer on the transmit path of the UART ALU.
- Accepts one ALU result word plus a status byte on a valid/ready input.
- Serializes them into a fixed byte frame on an AXI-stream byte output that feeds uart_tx (s_axis_tdata/tvalid/tready).
- Counterpart of the command-frame parser on the uart_rx side; frame format is symmetric with the command frame.

Parameters:
- DATA_WIDTH, 8, byte width of the output stream (fixed at 8; other values unsupported).
- RESULT_BYTES, 4, number of result bytes per frame; result width = 8*RESULT_BYTES.
- HEADER, 8'hA5, start-of-frame byte.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- s_result_tdata  input  8*RESULT_BYTES  ALU result word.
- s_result_tstatus  input  8  ALU flags: bit0 zero, bit1 carry, bit2 overflow, bit3 div-by-zero, bits7:4 reserved (passed through unchanged).
- s_result_tvalid  input  1  result available.
- s_result_tready  output  1  framer can capture a result.
- m_axis_tdata  output  8  frame byte to uart_tx.
- m_axis_tvalid  output  1  frame byte valid.
- m_axis_tready  input  1  uart_tx accepts byte.
- busy  output  1  frame in progress (state != IDLE).

Behaviour:
- Frame, in order: HEADER, status, result bytes LSB first (RESULT_BYTES of them), checksum. Total RESULT_BYTES+3 bytes (7 at default).
- Checksum: 8-bit sum mod 256 of the status byte and all result bytes. HEADER is excluded.
- States and transitions:
  - IDLE -> HDR on s_result_tvalid && s_result_tready. Result and status latched into internal registers on that edge.
  - HDR -> STAT on m_axis_tvalid && m_axis_tready.
  - STAT -> DATA on accept.
  - DATA -> CSUM on accept of byte index RESULT_BYTES-1. Byte index counter is $clog2(RESULT_BYTES) bits wide, cleared on entering DATA, incremented per accepted byte.
  - CSUM -> IDLE on accept.
- s_result_tready = (state == IDLE). Combinational from state only, never from s_result_tvalid.
- m_axis_tvalid = 1 in HDR/STAT/DATA/CSUM, 0 in IDLE. It does not depend on m_axis_tready.
- m_axis_tdata is driven from registered state, counter and latched data. It stays stable while tvalid=1 && tready=0 (AXI hold rule). It is 8'h00 in IDLE.
- Latency: capture at edge N; HEADER is valid from cycle N+1. With tready held high, the frame completes in 7 cycles. s_result_tready returns 1 the cycle after the checksum is accepted, so the minimum interval between captures is 8 cycles.
- Checksum accumulator: an 8-bit register, cleared at capture, added on each accepted status/data byte. Overflow wraps silently.
- Input asserted while busy: not captured (tready=0). The producer must hold it; it is captured on the first IDLE cycle.
- Reset (rst=0), asynchronous, at any time including mid-frame:
  - state = IDLE, counter = 0, checksum = 0, latched data = 0.
  - Outputs: m_axis_tvalid=0, m_axis_tdata=0, busy=0, s_result_tready=1 (once rst=1).
  - A partial frame is abandoned and no bytes are replayed.
- Reset release is synchronized externally; the block assumes deassertion is clean relative to clk.

Decomposition:
- Shared package alu_pkg:
  - resp_state_t enum (IDLE, HDR, STAT, DATA, CSUM).
  - RESP_HEADER = 8'hA5.
  - Status flag bit-index constants.
  - RESULT_BYTES default, shared with the command parser.
- No sub-module: one FSM, one counter and one accumulator in a single module.

Test Plan:
- Result 32'h12345678, status 8'h01, m_axis_tready=1 -> bytes A5 01 78 56 34 12 15 on 7 consecutive cycles starting the cycle after capture; busy drops after the last byte.
- Result 32'hFFFFFFFF, status 8'hFF -> A5 FF FF FF FF FF FB; checksum wraps (0x4FB -> 0xFB).
- Backpressure: same frame as scenario 1, m_axis_tready=0 for 3 cycles while byte 8'h56 is presented -> tdata holds 56 and tvalid stays 1; the frame resumes with 34 12 15.
- Second result 32'h000000AA, status 8'h00 presented during frame 1 -> s_result_tready=0 until frame 1 ends; then A5 00 AA 00 00 00 AA.
- rst=0 asserted during DATA byte 2 -> outputs go to 0 asynchronously; after release, a new result 32'h00000001, status 0 -> A5 00 01 00 00 00 01 with no stale bytes.
- Random results and status with random tready -> a scoreboard frame check matches the golden model for 1000 frames.
